fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, instruction address width in words.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, >=2.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc  input  ADDR_W  next fetch address from program counter.
REQ-007 SHALL have port flush  input  1  branch or jump taken this cycle; discard all fetched state.
REQ-008 SHALL have port consumed_inst  output  1  fetch at pc accepted; program counter advances next edge.
REQ-009 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-010 SHALL have port imem_addr  output  ADDR_W  read address, equals pc.
REQ-011 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  read data valid; responses return in request order.
REQ-013 SHALL have port imem_rdata  input  INST_W  read data.
REQ-014 SHALL have port dec_valid  output  1  head instruction available to decode.
REQ-015 SHALL have port dec_inst  output  INST_W  head instruction.
REQ-016 SHALL have port dec_pc  output  ADDR_W  address of head instruction.
REQ-017 SHALL have port dec_ready  input  1  decode accepts head; transfer when dec_valid&&dec_ready.

Function
REQ-018 SHALL keep a DEPTH-entry in-order queue; entry {pc, inst, filled}; slot allocated on grant, filled on rvalid.
REQ-019 SHALL assert imem_req = (state==RUN) && !flush && (allocated entries < DEPTH); combinational.
REQ-020 SHALL drive consumed_inst = imem_req && imem_gnt, same cycle; allocate tail with pc at that edge.
REQ-021 SHALL deassert imem_req and consumed_inst when queue full (DEPTH allocated).
REQ-022 SHALL write imem_rdata into oldest unfilled entry on imem_rvalid, unless response is being dropped (REQ-026).
REQ-023 SHALL assert dec_valid when head entry filled and !flush; retire head on dec_valid&&dec_ready.
REQ-024 SHALL permit allocate, fill and retire in the same cycle; pointers wrap modulo DEPTH.
REQ-025 SHALL, on flush, clear all entries at that edge and load drop counter with number of allocated-unfilled entries.
REQ-026 SHALL discard rvalid responses while drop counter >0, decrementing per response; rvalid in the flush cycle counts as already dropped (excluded from load).
REQ-027 SHALL implement FSM RUN/DRAIN: RUN->DRAIN on flush with nonzero drop load; DRAIN->RUN when counter reaches 0; flush in DRAIN reloads counter with remaining count.
REQ-028 SHALL ignore dec_ready handshake during flush cycle (dec_valid forced 0).
REQ-029 SHALL, without bypass, present filled data one cycle after imem_rvalid (registered).
REQ-030 SHALL never allocate more than DEPTH outstanding plus buffered; rvalid with no unfilled entry and drop counter 0 is a protocol error, ignored.

Reset
REQ-031 SHALL on rst low, asynchronously: queue empty, pointers 0, drop counter 0, state RUN.
REQ-032 SHALL output during reset: dec_valid=0, dec_inst=0, dec_pc=0; imem_req=0, consumed_inst=0 while rst low.
REQ-033 SHALL require instruction memory be reset by the same rst; in-flight responses at reset are not tracked.

Configuration
REQ-034 SHALL use macro FETCH_BYPASS_EN.
REQ-035 With FETCH_BYPASS_EN defined SHALL, when queue head is the unfilled target of imem_rvalid, drive dec_valid/dec_inst/dec_pc combinationally from imem_rdata that cycle; retire without storing if dec_ready.
REQ-036 Without FETCH_BYPASS_EN SHALL keep REQ-029 latency; no combinational path imem_rdata->dec_*.

Verification
REQ-037 Reset release, pc=0x0010, gnt=1 every cycle, rvalid one cycle after gnt, dec_ready=1 -> dec_pc sequence 0x0010,0x0011,... one per cycle after fill latency.
REQ-038 dec_ready=0, DEPTH=4 -> exactly 4 consumed_inst pulses, then imem_req=0 until dec_ready returns.
REQ-039 Two grants outstanding, flush asserted -> queue empty, 2 subsequent rvalid dropped, state DRAIN 2 cycles, third rvalid data appears at dec with new pc.
REQ-040 flush coincident with rvalid and one other outstanding -> drop counter loads 1, only next response dropped.
REQ-041 rst low mid-stream with 3 entries filled -> dec_valid=0, imem_req=0 immediately, queue empty after release.
REQ-042 FETCH_BYPASS_EN defined, empty queue, rvalid with 0xDEADBEEF, dec_ready=1 -> dec_valid=1, dec_inst=0xDEADBEEF same cycle; undefined -> next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a DEPTH-entry in-order queue.
// Requests are issued at the current pc and allocated in the queue when they
// are granted. Responses fill the entries in request order, and decode drains
// the queue from its head. A flush empties the queue and drops the responses
// that are still in flight.
// Optional build macro FETCH_BYPASS_EN: a response aimed at the empty queue
// head is passed straight through to decode in the same cycle.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              consumed_inst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic [PTR_W-1:0]  head, fill_ptr, tail;
    logic [CNT_W-1:0]  count, pend, drop_cnt, drop_next, outstanding;
    logic              alloc, fill, retire, bypass, head_filled;

    assign imem_addr   = pc;
    assign head_filled = filled[head];
    assign alloc       = consumed_inst;
    assign retire      = dec_valid && dec_ready;

    // Response bookkeeping: a response fills the queue unless it is being dropped.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no path infers a latch.
        fill        = imem_rvalid && !flush && (drop_cnt == '0) && (pend != '0);
        outstanding = drop_cnt + pend;
        drop_next   = drop_cnt;
        if (flush)
            drop_next = outstanding - CNT_W'(imem_rvalid && (outstanding != '0));
        else if (imem_rvalid && (drop_cnt != '0))
            drop_next = drop_cnt - CNT_W'(1);
`ifdef FETCH_BYPASS_EN
        bypass = fill && (fill_ptr == head);
`else
        bypass = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // FSM next state: wait in DRAIN until the stale responses have been dropped.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush && (drop_next != '0)) state_next = DRAIN;
            DRAIN:   if (drop_next == '0)            state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // FSM outputs: request while running with a free slot, and never during reset.
    always_comb begin
        imem_req      = rst && (state == RUN) && !flush && (count < CNT_W'(DEPTH));
        consumed_inst = imem_req && imem_gnt;
    end

    // Decode side: the head entry, or a bypassed response, with outputs zeroed when not valid.
    always_comb begin
        dec_valid = 1'b0;
        dec_inst  = '0;
        dec_pc    = '0;
        if (!flush && head_filled) begin
            dec_valid = 1'b1;
            dec_inst  = inst_q[head];
            dec_pc    = pc_q[head];
        end
`ifdef FETCH_BYPASS_EN
        else if (!flush && bypass) begin
            dec_valid = 1'b1;
            dec_inst  = imem_rdata;
            dec_pc    = pc_q[head];
        end
`endif
    end

    // Queue control: pointers, occupancy counters, fill flags and the drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
            filled   <= '0;
        end else if (flush) begin
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= drop_next;
            filled   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the later clear of a retiring
            // head wins over a bypass fill of the same slot, so that slot never stays marked filled.
            drop_cnt <= drop_next;
            if (alloc) begin
                tail         <= tail + PTR_W'(1);
                filled[tail] <= 1'b0;
            end
            if (fill) begin
                fill_ptr         <= fill_ptr + PTR_W'(1);
                filled[fill_ptr] <= 1'b1;
            end
            if (retire) begin
                head         <= head + PTR_W'(1);
                filled[head] <= 1'b0;
            end
            count <= count + CNT_W'(alloc) - CNT_W'(retire);
            pend  <= pend + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    // Queue payload storage.
    always_ff @(posedge clk) begin
        // NOTE: the payload is left without a reset on purpose; the filled flags gate every read of it.
        if (alloc) pc_q[tail]       <= pc;
        if (fill)  inst_q[fill_ptr] <= imem_rdata;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, self-checking bench for fetch_unit (DEPTH=4).
// Compile with +define+FETCH_BYPASS_EN to check the bypass build.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = '0;
    logic        flush = 1'b0;
    logic        consumed_inst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [15:0] dec_pc;
    logic        dec_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    fetch_unit #(.ADDR_W(16), .INST_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .consumed_inst(consumed_inst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; dec_ready = 1'b0; pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; dec_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        n_cmp++; if (dec_inst !== 32'h0) begin n_bad++; $display("FAIL reset_dec_inst: got %h want 0", dec_inst); end
        n_cmp++; if (dec_pc !== 16'h0) begin n_bad++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        n_cmp++; if (consumed_inst !== 1'b0) begin n_bad++; $display("FAIL reset_consumed: got %b want 0", consumed_inst); end
    endtask

    // Continuous stream: one grant per cycle, responses one cycle later, decode always ready.
    task automatic test_stream();
        logic        g;
        logic [15:0] a;
        int          lat;
        logic [15:0] exp_pc;
        do_reset();
        lat = BYP ? 1 : 2;
        pc = 16'h0010; imem_gnt = 1'b1; dec_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            g = consumed_inst; a = imem_addr;
            n_cmp++; if (consumed_inst !== 1'b1) begin n_bad++; $display("FAIL stream_consumed c%0d: got %b want 1", cyc, consumed_inst); end
            n_cmp++; if (imem_addr !== pc) begin n_bad++; $display("FAIL stream_addr c%0d: got %h want %h", cyc, imem_addr, pc); end
            if (cyc < lat) begin
                n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid c%0d: got %b want 0", cyc, dec_valid); end
            end else begin
                exp_pc = 16'h0010 + 16'(cyc - lat);
                n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want 1", cyc, dec_valid); end
                n_cmp++; if (dec_pc !== exp_pc) begin n_bad++; $display("FAIL stream_dec_pc c%0d: got %h want %h", cyc, dec_pc, exp_pc); end
                n_cmp++; if (dec_inst !== mk(exp_pc)) begin n_bad++; $display("FAIL stream_dec_inst c%0d: got %h want %h", cyc, dec_inst, mk(exp_pc)); end
            end
            next_cycle();
            imem_rvalid = g; imem_rdata = mk(a);
            if (g) pc = pc + 16'd1;
        end
    endtask

    // Decode stalled: the queue fills after four grants and requests stop.
    task automatic test_full();
        logic        g;
        logic [15:0] a;
        int          pulses;
        do_reset();
        pulses = 0;
        pc = 16'h0020; imem_gnt = 1'b1; dec_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            g = consumed_inst; a = imem_addr;
            if (g) pulses++;
            if (cyc == 7) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL full_req_low: got %b want 0", imem_req); end
            end
            next_cycle();
            imem_rvalid = g; imem_rdata = mk(a);
            if (g) pc = pc + 16'd1;
        end
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL full_pulses: got %0d want 4", pulses); end
        dec_ready = 1'b1;
        #1;
        n_cmp++; if (dec_pc !== 16'h0020) begin n_bad++; $display("FAIL full_head_pc: got %h want 0020", dec_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL full_req_still_low: got %b want 0", imem_req); end
        next_cycle();
        imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (consumed_inst !== 1'b1) begin n_bad++; $display("FAIL full_resume: got %b want 1", consumed_inst); end
        n_cmp++; if (imem_addr !== 16'h0024) begin n_bad++; $display("FAIL full_resume_addr: got %h want 0024", imem_addr); end
        n_cmp++; if (dec_pc !== 16'h0021) begin n_bad++; $display("FAIL full_next_pc: got %h want 0021", dec_pc); end
    endtask

    // Flush with two grants outstanding: both stale responses are dropped.
    task automatic test_flush();
        do_reset();
        pc = 16'h0030; imem_gnt = 1'b1; dec_ready = 1'b0;
        next_cycle(); pc = 16'h0031;
        next_cycle();
        imem_gnt = 1'b0; flush = 1'b1; pc = 16'h0080;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL flush_req: got %b want 0", imem_req); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dec_valid: got %b want 0", dec_valid); end
        next_cycle();
        flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = mk(16'h0030);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL drain1_req: got %b want 0", imem_req); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL drain1_dec_valid: got %b want 0", dec_valid); end
        next_cycle();
        imem_rdata = mk(16'h0031);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL drain2_req: got %b want 0", imem_req); end
        next_cycle();
        imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (consumed_inst !== 1'b1) begin n_bad++; $display("FAIL flush_resume: got %b want 1", consumed_inst); end
        n_cmp++; if (imem_addr !== 16'h0080) begin n_bad++; $display("FAIL flush_resume_addr: got %h want 0080", imem_addr); end
        next_cycle();
        imem_gnt = 1'b0; dec_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = mk(16'h0080);
        if (!BYP) begin
            next_cycle();
            imem_rvalid = 1'b0;
        end
        #1;
        n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL flush_new_valid: got %b want 1", dec_valid); end
        n_cmp++; if (dec_pc !== 16'h0080) begin n_bad++; $display("FAIL flush_new_pc: got %h want 0080", dec_pc); end
        n_cmp++; if (dec_inst !== mk(16'h0080)) begin n_bad++; $display("FAIL flush_new_inst: got %h want %h", dec_inst, mk(16'h0080)); end
    endtask

    // Flush coinciding with a response: only the single remaining response is dropped.
    task automatic test_flush_rvalid();
        do_reset();
        pc = 16'h0040; imem_gnt = 1'b1; dec_ready = 1'b0;
        next_cycle(); pc = 16'h0041;
        next_cycle();
        imem_gnt = 1'b0; flush = 1'b1; pc = 16'h0090; imem_rvalid = 1'b1; imem_rdata = mk(16'h0040);
        next_cycle();
        flush = 1'b0; imem_gnt = 1'b1; imem_rdata = mk(16'h0041);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL flrv_drain_req: got %b want 0", imem_req); end
        next_cycle();
        imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (consumed_inst !== 1'b1) begin n_bad++; $display("FAIL flrv_resume: got %b want 1", consumed_inst); end
        next_cycle();
        imem_gnt = 1'b0; dec_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = mk(16'h0090);
        if (!BYP) begin
            next_cycle();
            imem_rvalid = 1'b0;
        end
        #1;
        n_cmp++; if (dec_pc !== 16'h0090) begin n_bad++; $display("FAIL flrv_new_pc: got %h want 0090", dec_pc); end
        n_cmp++; if (dec_inst !== mk(16'h0090)) begin n_bad++; $display("FAIL flrv_new_inst: got %h want %h", dec_inst, mk(16'h0090)); end
    endtask

    // Reset asserted mid-stream with three filled entries.
    task automatic test_reset_mid();
        logic        g;
        logic [15:0] a;
        do_reset();
        pc = 16'h0050; imem_gnt = 1'b1; dec_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            g = consumed_inst; a = imem_addr;
            next_cycle();
            imem_rvalid = g; imem_rdata = mk(a);
            if (g) pc = pc + 16'd1;
        end
        imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", dec_valid); end
        n_cmp++; if (dec_pc !== 16'h0050) begin n_bad++; $display("FAIL mid_pre_pc: got %h want 0050", dec_pc); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", dec_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req: got %b want 0", imem_req); end
        n_cmp++; if (dec_pc !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_pc: got %h want 0000", dec_pc); end
        next_cycle();
        rst = 1'b1; imem_gnt = 1'b0;
        #1;
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL mid_post_valid: got %b want 0", dec_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mid_post_req: got %b want 1", imem_req); end
    endtask

    // Single response into an empty queue: same-cycle with bypass, next cycle without.
    task automatic test_bypass();
        do_reset();
        pc = 16'h0060; imem_gnt = 1'b1;
        next_cycle();
        imem_gnt = 1'b0; dec_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if (dec_valid !== BYP) begin n_bad++; $display("FAIL byp_same_valid: got %b want %b", dec_valid, BYP); end
        n_cmp++; if (dec_inst !== (BYP ? 32'hDEADBEEF : 32'h0)) begin n_bad++; $display("FAIL byp_same_inst: got %h want %h", dec_inst, BYP ? 32'hDEADBEEF : 32'h0); end
        next_cycle();
        imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        n_cmp++; if (dec_valid !== !BYP) begin n_bad++; $display("FAIL byp_next_valid: got %b want %b", dec_valid, !BYP); end
        n_cmp++; if (dec_inst !== (BYP ? 32'h0 : 32'hDEADBEEF)) begin n_bad++; $display("FAIL byp_next_inst: got %h want %h", dec_inst, BYP ? 32'h0 : 32'hDEADBEEF); end
        n_cmp++; if (dec_pc !== (BYP ? 16'h0 : 16'h0060)) begin n_bad++; $display("FAIL byp_next_pc: got %h want %h", dec_pc, BYP ? 16'h0 : 16'h0060); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_flush_rvalid();
        test_reset_mid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
